// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM encoding, second
// wrap value, default prescaler rate and a wrapping up/down step helper.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int         DEFAULT_TICKS_PER_SEC = 1000;
    localparam logic [7:0] SEC_WRAP              = 8'd59;

    // Step a field one position up or down, wrapping between 0 and top.
    function automatic logic [7:0] wrap_step(input logic [7:0] value,
                                             input logic [7:0] top,
                                             input logic       up);
        if (up) begin
            return (value == top) ? 8'd0 : value + 8'd1;
        end else begin
            return (value == 8'd0) ? top : value - 8'd1;
        end
    endfunction

endpackage

// File: rtl/timer_count_down_if.sv
// User-facing control and status bundle of the countdown timer; the master
// side drives the controls and observes time and status.
interface timer_count_down_if;

    logic       clr;
    logic       en;
    logic       enc_up;
    logic       enc_dn;
    logic       sel_min;
    logic       start_stop;
    logic [7:0] seconds;
    logic [7:0] minutes;
    logic       sec_minus_one;
    logic       borrow_min;
    logic       done;
    logic       buzzer;
    logic [1:0] state;

    modport master (
        output clr, en, enc_up, enc_dn, sel_min, start_stop,
        input  seconds, minutes, sec_minus_one, borrow_min, done, buzzer, state
    );

    modport slave (
        input  clr, en, enc_up, enc_dn, sel_min, start_stop,
        output seconds, minutes, sec_minus_one, borrow_min, done, buzzer, state
    );

endinterface

// File: rtl/timer_count_down_tick_gen.sv
// Prescaler for the countdown timer: counts 0..TICKS-1 while advance is high
// and flags the last count so the owner can treat it as a one-second tick.
module tick_gen #(
    parameter int TICKS = 1000,
    parameter int CW    = (TICKS > 1) ? $clog2(TICKS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          tick
);

    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick  = (count_q == LAST);
    assign count = count_q;

    // Clear beats advance; without advance the count holds any partial second.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (advance) begin
            count_d = tick ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/timer_count_down.sv
// Kitchen-style countdown timer: encoder-set mm:ss, start/pause/acknowledge
// button, per-second countdown and a 1 Hz buzzer once time runs out.
module timer_count_down
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
    parameter int MAX_MIN       = 99
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       enc_up,
    input  logic       enc_dn,
    input  logic       sel_min,
    input  logic       start_stop,
    output logic [7:0] seconds,
    output logic [7:0] minutes,
    output logic       sec_minus_one,
    output logic       borrow_min,
    output logic       done,
    output logic       buzzer,
    output logic [1:0] state
);

    localparam int            CW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [7:0]    MIN_TOP = 8'(MAX_MIN);
    localparam logic [CW-1:0] HALF    = CW'(TICKS_PER_SEC / 2);

    state_e        state_q, state_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    min_q, min_d;
    logic [CW-1:0] presc_count;
    logic          presc_tick;
    logic          presc_clear;
    logic          presc_advance;
    logic          time_zero;
    logic          sec_tick;

    assign time_zero = (sec_q == 8'd0) && (min_q == 8'd0);
    assign sec_tick  = (state_q == ST_RUN) && en && presc_tick;

    // A start_stop edge never advances the prescaler, so a tick that collides
    // with a pause stays pending and fires on the first cycle after resume.
    assign presc_clear   = clr || ((state_q == ST_IDLE) && start_stop && !time_zero);
    assign presc_advance = en && !start_stop && ((state_q == ST_RUN) || (state_q == ST_DONE));

    tick_gen #(
        .TICKS (TICKS_PER_SEC),
        .CW    (CW)
    ) u_tick_gen (
        .clk     (CLK),
        .rst_n   (rst_n),
        .clear   (presc_clear),
        .advance (presc_advance),
        .count   (presc_count),
        .tick    (presc_tick)
    );

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        if (clr) begin
            state_d = ST_IDLE;
            sec_d   = 8'd0;
            min_d   = 8'd0;
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE:  if (!time_zero) state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                ST_DONE:  state_d = ST_IDLE;
            endcase
        end else if (sec_tick) begin
            if (sec_q != 8'd0) begin
                sec_d = sec_q - 8'd1;
                if ((sec_q == 8'd1) && (min_q == 8'd0)) state_d = ST_DONE;
            end else if (min_q != 8'd0) begin
                sec_d = SEC_WRAP;
                min_d = min_q - 8'd1;
            end
        end else if ((state_q == ST_IDLE) && (enc_up ^ enc_dn)) begin
            if (sel_min) min_d = wrap_step(min_q, MIN_TOP, enc_up);
            else         sec_d = wrap_step(sec_q, SEC_WRAP, enc_up);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sec_q   <= 8'd0;
            min_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
        end
    end

    assign seconds       = sec_q;
    assign minutes       = min_q;
    assign state         = state_q;
    assign sec_minus_one = sec_tick;
    assign borrow_min    = sec_tick && (sec_q == 8'd0) && (min_q != 8'd0);
    assign done          = (state_q == ST_DONE);
    assign buzzer        = (state_q == ST_DONE) && (presc_count < HALF);

endmodule
